// File: rtl/event_mask_gen.sv
// Per-channel carrier event decimator: counts rising edges of event_in and emits
// one-cycle mask pulses in bypass, periodic-decimate or one-shot mode.
module event_mask_gen #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       event_in,
  input  logic                 pwm_on,
  input  logic                 carr_on,
  input  logic [2*NCH-1:0]     mode,
  input  logic [CNT_W*NCH-1:0] event_count,
  input  logic [CNT_W*NCH-1:0] event_offset,
  input  logic [NCH-1:0]       load,
  output logic [NCH-1:0]       mask_out,
  output logic [CNT_W*NCH-1:0] cnt_out,
  output logic [NCH-1:0]       armed
);

  typedef enum logic [1:0] {
    MODE_BYPASS   = 2'b00,
    MODE_DECIMATE = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_OFF      = 2'b11
  } mode_e;

  logic             active;
  logic [NCH-1:0]   evt_q;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [NCH-1:0]   armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];

  assign active = pwm_on & carr_on;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      mask_d[i]  = 1'b0;
      armed_d[i] = armed_q[i];
      cnt_d[i]   = cnt_q[i];
      case (mode_e'(mode[2*i +: 2]))
        MODE_OFF: begin
          cnt_d[i]   = '0;
          armed_d[i] = 1'b1;
        end
        default: begin
          // Load wins over a coincident rise; the event is dropped.
          if (load[i]) begin
            cnt_d[i]   = (event_offset[CNT_W*i +: CNT_W] < event_count[CNT_W*i +: CNT_W])
                         ? event_offset[CNT_W*i +: CNT_W]
                         : event_count[CNT_W*i +: CNT_W];
            armed_d[i] = 1'b1;
          end else if (active && event_in[i] && !evt_q[i]) begin
            if (mode_e'(mode[2*i +: 2]) == MODE_BYPASS) begin
              mask_d[i] = 1'b1;
            end else if (cnt_q[i] >= event_count[CNT_W*i +: CNT_W]) begin
              // >= lets a lowered terminal count wrap on the next event.
              cnt_d[i]  = '0;
              mask_d[i] = (mode_e'(mode[2*i +: 2]) == MODE_DECIMATE) || armed_q[i];
              if (mode_e'(mode[2*i +: 2]) == MODE_ONESHOT) armed_d[i] = 1'b0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // evt_q tracks event_in even while inactive so re-enabling never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_q   <= '0;
      mask_q  <= '0;
      armed_q <= '1;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      evt_q   <= event_in;
      mask_q  <= mask_d;
      armed_q <= armed_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign mask_out = mask_q;
  assign armed    = armed_q;

  for (genvar g = 0; g < NCH; g++) begin : g_cnt
    assign cnt_out[CNT_W*g +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_event_mask_gen.sv
// Directed bench for event_mask_gen: behavioural model checked every cycle plus
// hand-computed expectations for each scenario.
module tb_event_mask_gen;
  localparam int NCH = 4;
  localparam int W   = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   event_in;
  logic             pwm_on, carr_on;
  logic [2*NCH-1:0] mode;
  logic [W*NCH-1:0] event_count, event_offset;
  logic [NCH-1:0]   load;
  logic [NCH-1:0]   mask_out;
  logic [W*NCH-1:0] cnt_out;
  logic [NCH-1:0]   armed;

  int checks = 0;
  int errors = 0;

  event_mask_gen #(.NCH(NCH), .CNT_W(W)) dut (
    .clk(clk), .reset(reset), .event_in(event_in), .pwm_on(pwm_on),
    .carr_on(carr_on), .mode(mode), .event_count(event_count),
    .event_offset(event_offset), .load(load), .mask_out(mask_out),
    .cnt_out(cnt_out), .armed(armed)
  );

  always #5 clk = ~clk;

  // Behavioural model: counter value = events seen since the last wrap.
  int m_cnt   [NCH];
  bit m_armed [NCH];
  bit m_mask  [NCH];
  bit m_prev  [NCH];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_cnt[c] <= 0; m_armed[c] <= 1'b1; m_mask[c] <= 1'b0; m_prev[c] <= 1'b0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        automatic int md  = int'(mode[2*c +: 2]);
        automatic int n   = int'(event_count[W*c +: W]);
        automatic int ofs = int'(event_offset[W*c +: W]);
        automatic bit ev  = event_in[c] && !m_prev[c];
        m_prev[c] <= event_in[c];
        m_mask[c] <= 1'b0;
        if (md == 3) begin
          m_cnt[c] <= 0; m_armed[c] <= 1'b1;
        end else if (load[c]) begin
          m_cnt[c] <= (ofs < n) ? ofs : n; m_armed[c] <= 1'b1;
        end else if (pwm_on && carr_on && ev) begin
          if (md == 0) m_mask[c] <= 1'b1;
          else if (m_cnt[c] + 1 <= n) m_cnt[c] <= m_cnt[c] + 1;
          else begin
            m_cnt[c]  <= 0;
            m_mask[c] <= (md == 1) || m_armed[c];
            if (md == 2) m_armed[c] <= 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    checks = checks + 1;
    if (act != expv) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("model_mask%0d", c), int'(mask_out[c]), int'(m_mask[c]));
        chk($sformatf("model_cnt%0d", c), int'(cnt_out[W*c +: W]), m_cnt[c]);
        chk($sformatf("model_armed%0d", c), int'(armed[c]), int'(m_armed[c]));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int ch, output logic m, output int c);
    event_in[ch] = 1'b1;
    @(negedge clk);
    m = mask_out[ch];
    c = int'(cnt_out[W*ch +: W]);
    event_in[ch] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_load(input int ch);
    load[ch] = 1'b1;
    @(negedge clk);
    load[ch] = 1'b0;
  endtask

  task automatic set_cnt(input int ch, input int v);
    event_count[W*ch +: W] = W'(v);
  endtask

  task automatic set_ofs(input int ch, input int v);
    event_offset[W*ch +: W] = W'(v);
  endtask

  logic m;
  int   c;
  int   npulse;

  initial begin
    reset = 1'b1; event_in = '0; load = '0; pwm_on = 1'b1; carr_on = 1'b1;
    mode = {2'b01, 2'b10, 2'b01, 2'b00};
    event_count = '0; event_offset = '0;
    set_cnt(1, 3); set_cnt(2, 1); set_cnt(3, 7);
    idle(2);
    chk("rst_cnt", int'(cnt_out), 0);
    chk("rst_mask", int'(mask_out), 0);
    chk("rst_armed", int'(armed), 15);
    reset = 1'b0;

    // Bypass on ch0
    for (int k = 0; k < 2; k++) begin
      idle(8);
      pulse(0, m, c);
      chk("byp_mask", int'(m), 1);
      chk("byp_cnt", c, 0);
      chk("byp_width", int'(mask_out[0]), 0);
    end

    // Some ch3 traffic that must not disturb other channels
    repeat (3) pulse(3, m, c);
    chk("ch3_cnt", c, 3);

    // Decimate by 4 on ch1
    for (int k = 1; k <= 12; k++) begin
      pulse(1, m, c);
      chk("dec_cnt", c, k % 4);
      chk("dec_mask", int'(m), (k % 4 == 0) ? 1 : 0);
    end
    event_in[1] = 1'b1;
    idle(50);
    event_in[1] = 1'b0;
    idle(1);
    chk("hold_cnt", int'(cnt_out[W*1 +: W]), 1);

    // Offset load and priority on ch1
    set_cnt(1, 4); set_ofs(1, 3);
    do_load(1);
    chk("load_cnt", int'(cnt_out[W*1 +: W]), 3);
    pulse(1, m, c); chk("ofs_cnt4", c, 4); chk("ofs_mask0", int'(m), 0);
    pulse(1, m, c); chk("ofs_cnt0", c, 0); chk("ofs_mask1", int'(m), 1);
    event_in[1] = 1'b1; load[1] = 1'b1;
    @(negedge clk);
    chk("prio_mask", int'(mask_out[1]), 0);
    chk("prio_cnt", int'(cnt_out[W*1 +: W]), 3);
    event_in[1] = 1'b0; load[1] = 1'b0;
    idle(1);
    set_ofs(1, 9);
    do_load(1);
    chk("clamp_cnt", int'(cnt_out[W*1 +: W]), 4);

    // One-shot on ch2 with N=1
    for (int k = 1; k <= 6; k++) begin
      pulse(2, m, c);
      chk("os_mask", int'(m), (k == 2) ? 1 : 0);
      chk("os_cnt", c, k % 2);
      chk("os_armed", int'(armed[2]), (k < 2) ? 1 : 0);
    end
    do_load(2);
    chk("os_rearm", int'(armed[2]), 1);
    pulse(2, m, c); chk("os_r1_mask", int'(m), 0);
    pulse(2, m, c); chk("os_r2_mask", int'(m), 1);
    chk("os_r2_armed", int'(armed[2]), 0);

    // Gating and terminal-count shrink on ch3
    set_ofs(3, 5);
    do_load(3);
    chk("gate_load", int'(cnt_out[W*3 +: W]), 5);
    carr_on = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pulse(3, m, c);
      chk("gate_mask", int'(m), 0);
      chk("gate_cnt", c, 5);
    end
    carr_on = 1'b1;
    set_cnt(3, 2);
    pulse(3, m, c);
    chk("shrink_mask", int'(m), 1);
    chk("shrink_cnt", c, 0);

    // Maximum terminal count: one pulse per 256 events
    set_cnt(3, 255); set_ofs(3, 0);
    do_load(3);
    npulse = 0;
    for (int k = 1; k <= 256; k++) begin
      pulse(3, m, c);
      if (m) npulse++;
    end
    chk("max_pulses", npulse, 1);
    chk("max_last", int'(m), 1);

    // N=0 emits on every event
    mode[1:0] = 2'b01; set_cnt(0, 0);
    idle(1);
    for (int k = 0; k < 3; k++) begin
      pulse(0, m, c);
      chk("n0_mask", int'(m), 1);
    end

    // OFF mode on ch3: forced clear, load ignored
    mode[7:6] = 2'b11;
    idle(1);
    chk("off_cnt", int'(cnt_out[W*3 +: W]), 0);
    chk("off_armed", int'(armed[3]), 1);
    set_ofs(3, 7);
    do_load(3);
    pulse(3, m, c);
    chk("off_load_cnt", c, 0);
    chk("off_mask", int'(m), 0);

    // Asynchronous reset mid-count on ch1
    set_ofs(1, 2);
    do_load(1);
    chk("pre_rst_cnt", int'(cnt_out[W*1 +: W]), 2);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_cnt", int'(cnt_out), 0);
    chk("arst_mask", int'(mask_out), 0);
    chk("arst_armed", int'(armed), 15);
    event_in[0] = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rise", int'(mask_out[0]), 1);
    event_in[0] = 1'b0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
